riscv_signature_decoder: RTL and testbench

//  Testbench-side controller that sequences the signature-write protocol.
//  - Snoops core data-bus writes; matches SIG_ADDR; decodes the type byte.
//  - Walks multi-beat sequences: WRITE_GPR = header + NUM_GPR data beats; WRITE_CSR = header + 1 data beat.
//  - Presents decoded status, test result, GPR and CSR events to the UVM monitor as registered single-cycle pulses.

---
 rtl/riscv_signature_pkg.sv | 43 ++++
 rtl/riscv_signature_decoder.sv | 120 ++++++++++++
 tb/tb_riscv_signature_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_signature_pkg.sv
// riscv_signature_pkg: signature-protocol types, field positions and decoder state encoding
package riscv_signature_pkg;

    typedef enum logic [7:0] {
        CORE_STATUS = 8'd0,
        TEST_RESULT = 8'd1,
        WRITE_GPR   = 8'd2,
        WRITE_CSR   = 8'd3
    } signature_type_t;

    typedef enum logic [4:0] {
        INITIALIZED             = 5'd0,
        IN_DEBUG_MODE           = 5'd1,
        IN_MACHINE_MODE         = 5'd2,
        IN_HYPERVISOR_MODE      = 5'd3,
        IN_SUPERVISOR_MODE      = 5'd4,
        IN_USER_MODE            = 5'd5,
        HANDLING_IRQ            = 5'd6,
        FINISHED_IRQ            = 5'd7,
        HANDLING_EXCEPTION      = 5'd8,
        INSTR_FAULT_EXCEPTION   = 5'd9,
        ILLEGAL_INSTR_EXCEPTION = 5'd10,
        LOAD_FAULT_EXCEPTION    = 5'd11,
        STORE_FAULT_EXCEPTION   = 5'd12,
        EBREAK_EXCEPTION        = 5'd13
    } core_status_t;

    typedef enum logic {
        TEST_PASS = 1'b0,
        TEST_FAIL = 1'b1
    } test_result_t;

    localparam int SIG_TYPE_LSB    = 0;
    localparam int SIG_PAYLOAD_LSB = 8;
    localparam int SIG_CSR_ADDR_W  = 12;

    typedef enum logic [1:0] {
        SIG_IDLE,
        SIG_GPR_DUMP,
        SIG_CSR_DATA
    } sig_dec_state_t;

endpackage

// File: rtl/riscv_signature_decoder.sv
// riscv_signature_decoder: snoops bus writes to SIG_ADDR and decodes the signature protocol into pulses
// Ports: clk, rst (sync, active-high); wr_valid/wr_addr/wr_be/wr_data bus snoop;
//   status_vld/status, result_vld/result_fail, gpr_vld/gpr_idx/gpr_data, csr_vld/csr_addr/csr_data, busy.
// Optional macro RISCV_SIG_DECODER_CHECK_EN adds sticky proto_err and a gpr/csr exclusivity assertion.
module riscv_signature_decoder
    import riscv_signature_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] SIG_ADDR = 32'h8000_0000,
    parameter int          NUM_GPR  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [XLEN/8-1:0]         wr_be,
    input  logic [XLEN-1:0]           wr_data,
    output logic                      status_vld,
    output logic [4:0]                status,
    output logic                      result_vld,
    output logic                      result_fail,
    output logic                      gpr_vld,
    output logic [4:0]                gpr_idx,
    output logic [XLEN-1:0]           gpr_data,
    output logic                      csr_vld,
    output logic [SIG_CSR_ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]           csr_data,
    output logic                      busy
`ifdef RISCV_SIG_DECODER_CHECK_EN
    ,
    output logic                      proto_err
`endif
);

    localparam int CNT_W = $clog2(NUM_GPR) + 1;

    sig_dec_state_t  state_q, state_d;
    signature_type_t sig_type;
    logic [CNT_W-1:0] count;
    logic sig_hit, beat, last_gpr;

    assign sig_hit  = wr_valid && (wr_addr == ADDR_W'(SIG_ADDR));
    assign beat     = sig_hit && (&wr_be);
    assign sig_type = signature_type_t'(wr_data[SIG_TYPE_LSB +: 8]);
    assign last_gpr = count == CNT_W'(NUM_GPR - 1);
    assign busy     = state_q != SIG_IDLE;

    always_comb begin
        state_d = state_q;
        if (beat)
            state_d = state_q == SIG_IDLE ? (sig_type == WRITE_GPR ? SIG_GPR_DUMP :
                                             sig_type == WRITE_CSR ? SIG_CSR_DATA : SIG_IDLE) :
                      state_q == SIG_GPR_DUMP ? (last_gpr ? SIG_IDLE : SIG_GPR_DUMP) : SIG_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SIG_IDLE;
            count       <= '0;
            status_vld  <= 1'b0;
            status      <= 5'(INITIALIZED);
            result_vld  <= 1'b0;
            result_fail <= 1'b0;
            gpr_vld     <= 1'b0;
            gpr_idx     <= '0;
            gpr_data    <= '0;
            csr_vld     <= 1'b0;
            csr_addr    <= '0;
            csr_data    <= '0;
        end else begin
            state_q    <= state_d;
            status_vld <= 1'b0;
            result_vld <= 1'b0;
            gpr_vld    <= 1'b0;
            csr_vld    <= 1'b0;
            if (beat) begin
                case (state_q)
                    SIG_IDLE: begin
                        if (sig_type == CORE_STATUS) begin
                            status     <= wr_data[SIG_PAYLOAD_LSB +: 5];
                            status_vld <= 1'b1;
                        end
                        if (sig_type == TEST_RESULT) begin
                            result_fail <= wr_data[SIG_PAYLOAD_LSB];
                            result_vld  <= 1'b1;
                        end
                        if (sig_type == WRITE_GPR)
                            count <= '0;
                        if (sig_type == WRITE_CSR)
                            csr_addr <= wr_data[SIG_PAYLOAD_LSB +: SIG_CSR_ADDR_W];
                    end
                    SIG_GPR_DUMP: begin
                        gpr_vld  <= 1'b1;
                        gpr_idx  <= 5'(count);
                        gpr_data <= wr_data;
                        count    <= count + 1'b1;
                    end
                    default: begin
                        csr_vld  <= 1'b1;
                        csr_data <= wr_data;
                    end
                endcase
            end
        end
    end

`ifdef RISCV_SIG_DECODER_CHECK_EN
    // A partial write to the signature word is malformed no matter which state we are in.
    always_ff @(posedge clk) begin
        if (rst)
            proto_err <= 1'b0;
        else if ((sig_hit && !(&wr_be)) || (beat && state_q == SIG_IDLE && sig_type > WRITE_CSR))
            proto_err <= 1'b1;
    end

    a_gpr_csr_excl: assert property (@(posedge clk) disable iff (rst) !(gpr_vld && csr_vld));
`endif

endmodule

// File: tb/tb_riscv_signature_decoder.sv
// tb_riscv_signature_decoder: directed vectors against a protocol-level model of the signature decoder
module tb_riscv_signature_decoder;

    localparam logic [31:0] SIG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        status_vld, result_vld, result_fail, gpr_vld, csr_vld, busy;
    logic [4:0]  status, gpr_idx;
    logic [31:0] gpr_data, csr_data;
    logic [11:0] csr_addr;
`ifdef RISCV_SIG_DECODER_CHECK_EN
    logic        proto_err;
`endif

    riscv_signature_decoder dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .status_vld(status_vld), .status(status), .result_vld(result_vld), .result_fail(result_fail),
        .gpr_vld(gpr_vld), .gpr_idx(gpr_idx), .gpr_data(gpr_data),
        .csr_vld(csr_vld), .csr_addr(csr_addr), .csr_data(csr_data), .busy(busy)
`ifdef RISCV_SIG_DECODER_CHECK_EN
        , .proto_err(proto_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int gpr_pulses = 0;
    int csr_pulses = 0;

    // Model: expected DUT outputs for the cycle after the currently driven inputs.
    logic        e_sv = 0, e_rv = 0, e_gv = 0, e_cv = 0, e_fail = 0, e_err = 0;
    logic [4:0]  e_status = 0, e_idx = 0;
    logic [31:0] e_gdata = 0, e_cdata = 0;
    logic [11:0] e_caddr = 0;
    int          gpr_left = 0;
    bit          csr_pend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d);
        {e_sv, e_rv, e_gv, e_cv} = '0;
        if (r) begin
            {e_fail, e_err} = '0;
            e_status = 0; e_idx = 0; e_gdata = 0; e_cdata = 0; e_caddr = 0;
            gpr_left = 0; csr_pend = 0;
        end else if (v && a == SIG) begin
            if (be != 4'hf) e_err = 1;
            else if (gpr_left > 0) begin
                e_gv = 1; e_idx = 5'(32 - gpr_left); e_gdata = d; gpr_left--;
            end else if (csr_pend) begin
                e_cv = 1; e_cdata = d; csr_pend = 0;
            end else if (d[7:0] == 0) begin
                e_sv = 1; e_status = d[12:8];
            end else if (d[7:0] == 1) begin
                e_rv = 1; e_fail = d[8];
            end else if (d[7:0] == 2) gpr_left = 32;
            else if (d[7:0] == 3) begin
                e_caddr = d[19:8]; csr_pend = 1;
            end else e_err = 1;
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d);
        @(negedge clk);
        rst = r; wr_valid = v; wr_addr = a; wr_be = be; wr_data = d;
        model(r, v, a, be, d);
    endtask

    task automatic sig(input logic [31:0] d);
        drive(0, 1, SIG, 4'hf, d);
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, '0);
    endtask

    always @(posedge clk) begin
        #1;
        chk("status_vld", 32'(status_vld), 32'(e_sv));
        chk("status", 32'(status), 32'(e_status));
        chk("result_vld", 32'(result_vld), 32'(e_rv));
        chk("result_fail", 32'(result_fail), 32'(e_fail));
        chk("gpr_vld", 32'(gpr_vld), 32'(e_gv));
        chk("gpr_idx", 32'(gpr_idx), 32'(e_idx));
        chk("gpr_data", gpr_data, e_gdata);
        chk("csr_vld", 32'(csr_vld), 32'(e_cv));
        chk("csr_addr", 32'(csr_addr), 32'(e_caddr));
        chk("csr_data", csr_data, e_cdata);
        chk("busy", 32'(busy), 32'(gpr_left > 0 || csr_pend));
`ifdef RISCV_SIG_DECODER_CHECK_EN
        chk("proto_err", 32'(proto_err), 32'(e_err));
`endif
        if (gpr_vld) gpr_pulses++;
        if (csr_vld) csr_pulses++;
    end

    initial begin
        drive(1, 0, '0, '0, '0);
        drive(1, 0, '0, '0, '0);
        idle();
        chk("reset_status", 32'(status), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        sig(32'h0000_0200);
        idle();
        chk("t1_status", 32'(status), 32'd2);

        sig(32'h0000_0101);
        sig(32'h0000_0001);
        idle();
        chk("t2_fail_cleared", 32'(result_fail), 32'd0);

        gpr_pulses = 0;
        sig(32'h0000_0002);
        for (int i = 0; i < 32; i++) begin
            sig(32'(i * 4));
            if (i == 15) idle();
        end
        sig(32'h0000_0200);
        idle();
        chk("t3_gpr_pulses", 32'(gpr_pulses), 32'd32);
        chk("t3_last_idx", 32'(gpr_idx), 32'd31);
        chk("t3_last_data", gpr_data, 32'd124);
        chk("t3_status_after", 32'(status), 32'd2);

        csr_pulses = 0;
        sig(32'h0003_0003);
        drive(0, 1, 32'h8000_0004, 4'hf, 32'h1234_5678);
        drive(0, 1, SIG, 4'b0011, 32'h5555_0000);
        idle();
        sig(32'hDEAD_BEEF);
        idle();
        chk("t4_csr_pulses", 32'(csr_pulses), 32'd1);
        chk("t4_csr_addr", 32'(csr_addr), 32'h300);
        chk("t4_csr_data", csr_data, 32'hDEAD_BEEF);

        gpr_pulses = 0;
        sig(32'h0000_0002);
        for (int i = 0; i < 11; i++) sig(32'hA000_0000 + 32'(i));
        drive(1, 1, SIG, 4'hf, 32'hBAD0_0000);
        idle();
        idle();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_gpr_pulses", 32'(gpr_pulses), 32'd11);
        sig(32'h0000_0300);
        idle();
        chk("t5_status", 32'(status), 32'd3);

        sig(32'h0000_0007);
        drive(0, 1, SIG, 4'b0011, 32'h0000_0000);
        idle();
        idle();
        chk("t6_busy", 32'(busy), 32'd0);
`ifdef RISCV_SIG_DECODER_CHECK_EN
        chk("t6_proto_err", 32'(proto_err), 32'd1);
`endif
        sig(32'h0000_0101);
        idle();
        chk("t6_result_after", 32'(result_fail), 32'd1);

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
